// File: rtl/div_clk_monitor_pkg.sv
// Shared definitions for the divided-clock lock/period monitor.
//   state_t        : monitor FSM encoding (3 bits)
//   MissW          : width of the saturating miss counter
//   timeout_cycles : source-cycle count after which a missing rise is a bad period
package div_clk_monitor_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAcq    = 3'd1,
        StMeas   = 3'd2,
        StLocked = 3'd3,
        StResync = 3'd4
    } state_t;

    localparam int unsigned MissW = 8;

    // A period this long without a rise is treated as a lost edge.
    function automatic int unsigned timeout_cycles(input int unsigned div, input int unsigned tol);
        return 2 * div + tol;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus delay flop and rising-edge detect.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset
//   din   : asynchronous level to sample
//   level : synchronized level
//   rise  : one-cycle high when the synchronized level goes 0 -> 1
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic meta;
    logic s;
    logic s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            s    <= 1'b0;
            s_d  <= 1'b0;
        end else begin
            meta <= din;
            s    <= meta;
            s_d  <= s;
        end
    end

    assign level = s;
    assign rise  = s & ~s_d;

endmodule

// File: rtl/div_clk_monitor.sv
// Lock and period monitor for the integer clock divider output.
// Measures period and high time of DIV_CLK in source cycles, declares lock after
// LOCK_CNT consecutive in-tolerance periods, and pulses SYNC back to the divider
// after a bad or missing period.
//   CLK_in  : source clock (same as the divider's)
//   RST     : asynchronous active-low reset
//   EN      : monitor enable; low returns to idle and clears ERR/MISS
//   DIV_CLK : divided clock under test
//   SYNC    : one-cycle re-align pulse to the divider
//   LOCK    : divided clock in tolerance
//   ERR     : sticky, set on a bad period while locked
//   VALID   : one-cycle strobe, PERIOD/HIGH_T updated
//   PERIOD  : source cycles between the last two rises
//   HIGH_T  : source cycles DIV_CLK was high in that period
//   MISS    : saturating count of bad or timed-out periods
module div_clk_monitor
    import div_clk_monitor_pkg::*;
#(
    parameter int unsigned DIV      = 2,
    parameter int unsigned TOL      = 0,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned W        = 16
) (
    input  logic             CLK_in,
    input  logic             RST,
    input  logic             EN,
    input  logic             DIV_CLK,
    output logic             SYNC,
    output logic             LOCK,
    output logic             ERR,
    output logic             VALID,
    output logic [W-1:0]     PERIOD,
    output logic [W-1:0]     HIGH_T,
    output logic [MissW-1:0] MISS
);

    if (DIV < 2) begin : g_div_check
        $error("div_clk_monitor: DIV must be >= 2");
    end
    if (LOCK_CNT < 1) begin : g_lock_check
        $error("div_clk_monitor: LOCK_CNT must be >= 1");
    end
    if (64'(timeout_cycles(DIV, TOL)) >= (64'd1 << W)) begin : g_width_check
        $error("div_clk_monitor: timeout does not fit in W bits");
    end

    localparam int unsigned         GoodW    = $clog2(LOCK_CNT + 1);
    localparam logic [GoodW-1:0]    LockLast = GoodW'(LOCK_CNT - 1);
    localparam logic [W:0]          DivW     = (W + 1)'(DIV);
    localparam logic [W:0]          TolW     = (W + 1)'(TOL);
    localparam logic [W-1:0]        TimeoutW = W'(timeout_cycles(DIV, TOL));

    state_t           state;
    logic [W-1:0]     cnt;
    logic [W-1:0]     hcnt;
    logic [GoodW-1:0] good_cnt;

    logic             s;
    logic             rise;
    logic [W:0]       per_full;
    logic [W-1:0]     per_sat;
    logic [W-1:0]     cnt_inc;
    logic [W-1:0]     hcnt_inc;
    logic [MissW-1:0] miss_inc;
    logic             good;
    logic             timeout;
    logic             bad_period;

    sync_edge_det u_sync (
        .clk   (CLK_in),
        .rst_n (RST),
        .din   (DIV_CLK),
        .level (s),
        .rise  (rise)
    );

    always_comb begin
        // One extra bit so cnt+1 cannot wrap before the tolerance test.
        per_full   = {1'b0, cnt} + (W + 1)'(1);
        per_sat    = per_full[W] ? '1 : per_full[W-1:0];
        cnt_inc    = (cnt == '1) ? cnt : cnt + W'(1);
        hcnt_inc   = (hcnt == '1) ? hcnt : hcnt + W'(s);
        miss_inc   = (MISS == '1) ? MISS : MISS + MissW'(1);
        good       = (per_full >= DivW) ? ((per_full - DivW) <= TolW)
                                        : ((DivW - per_full) <= TolW);
        // A rise in the same cycle wins over the timeout.
        timeout    = (cnt == TimeoutW) && !rise;
        bad_period = (rise && !good) || timeout;
    end

    always_ff @(posedge CLK_in or negedge RST) begin
        if (!RST) begin
            state    <= StIdle;
            cnt      <= '0;
            hcnt     <= '0;
            good_cnt <= '0;
            SYNC     <= 1'b0;
            LOCK     <= 1'b0;
            ERR      <= 1'b0;
            VALID    <= 1'b0;
            PERIOD   <= '0;
            HIGH_T   <= '0;
            MISS     <= '0;
        end else begin
            VALID <= 1'b0;
            SYNC  <= 1'b0;
            if (rise) begin
                cnt  <= '0;
                hcnt <= W'(1);  // the rise cycle itself is high
            end else begin
                cnt  <= cnt_inc;
                hcnt <= hcnt_inc;
            end

            if (!EN) begin
                state    <= StIdle;
                cnt      <= '0;
                hcnt     <= '0;
                good_cnt <= '0;
                LOCK     <= 1'b0;
                ERR      <= 1'b0;
                MISS     <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        cnt      <= '0;
                        hcnt     <= '0;
                        good_cnt <= '0;
                        ERR      <= 1'b0;
                        MISS     <= '0;
                        state    <= StAcq;
                    end
                    StAcq: begin
                        if (rise) begin
                            state <= StMeas;
                        end else if (timeout) begin
                            MISS  <= miss_inc;
                            state <= StResync;
                        end
                    end
                    StMeas: begin
                        if (rise) begin
                            PERIOD <= per_sat;
                            HIGH_T <= hcnt;
                            VALID  <= 1'b1;
                        end
                        if (bad_period) begin
                            good_cnt <= '0;
                            MISS     <= miss_inc;
                            state    <= StResync;
                        end else if (rise) begin
                            good_cnt <= good_cnt + GoodW'(1);
                            if (good_cnt == LockLast) begin
                                LOCK  <= 1'b1;
                                state <= StLocked;
                            end
                        end
                    end
                    StLocked: begin
                        if (rise) begin
                            PERIOD <= per_sat;
                            HIGH_T <= hcnt;
                            VALID  <= 1'b1;
                        end
                        if (bad_period) begin
                            good_cnt <= '0;
                            MISS     <= miss_inc;
                            ERR      <= 1'b1;
                            LOCK     <= 1'b0;
                            state    <= StResync;
                        end
                    end
                    StResync: begin
                        // Counters restart so the next ACQ wait is a full one.
                        SYNC     <= 1'b1;
                        good_cnt <= '0;
                        cnt      <= '0;
                        hcnt     <= '0;
                        state    <= StAcq;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
